// File: rtl/maze_move_input_if.sv
// ---------------------------------------------------------------------------
// maze_move_input_if
// Move handshake between the input-conditioning stage and the maze core.
//   move_valid : a move is presented (driven by the input stage)
//   move_dir   : 00=up, 01=down, 10=left, 11=right, meaningful while valid
//   move_ready : the maze core takes the presented move this cycle
// The master modport is the input stage; the slave modport is the maze core.
// ---------------------------------------------------------------------------
interface maze_move_input_if;
    logic       move_valid;
    logic [1:0] move_dir;
    logic       move_ready;

    modport master (output move_valid, output move_dir, input move_ready);
    modport slave  (input move_valid, input move_dir, output move_ready);
endinterface

// File: rtl/maze_move_input.sv
// ---------------------------------------------------------------------------
// maze_move_input
// Turns four raw direction buttons into single move commands for the maze core.
// Each button is synchronised and debounced. The debounced levels drive a
// press / hold-to-repeat event generator, and each move is held in a one-entry
// output register until the maze core takes it.
// Ports:
//   clk          : system clock, all state on the rising edge
//   rst_n        : asynchronous active-low reset
//   i_ena        : enable; when low no new moves are generated
//   i_btn_raw    : raw buttons [0]=up [1]=down [2]=left [3]=right, active high
//   move_bus     : valid/ready move handshake towards the maze core (master)
//   o_btn_stable : debounced button levels
//   o_overrun    : sticky, a move was dropped because the output was occupied
// ---------------------------------------------------------------------------
module maze_move_input #(
    parameter int DEB_CYCLES = 16,
    parameter int REP_DELAY  = 64,
    parameter int REP_PERIOD = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      i_ena,
    input  logic [3:0]                i_btn_raw,
    maze_move_input_if.master         move_bus,
    output logic [3:0]                o_btn_stable,
    output logic                      o_overrun
);

    localparam int CW   = $clog2(DEB_CYCLES + 1);
    localparam int TMAX = (REP_DELAY > REP_PERIOD) ? REP_DELAY : REP_PERIOD;
    localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;

    typedef enum logic [1:0] {IDLE, DELAY, REPEAT} state_t;

    logic [3:0]    r_sync1;
    logic [3:0]    r_sync2;
    logic [CW-1:0] r_debCnt [4];
    logic [3:0]    r_btnStable;

    state_t        r_state;
    state_t        w_stateNext;
    logic [TW-1:0] r_timer;
    logic [TW-1:0] w_timerNext;
    logic [1:0]    r_curDir;
    logic [1:0]    w_curDirNext;

    logic          w_any;
    logic [1:0]    w_sel;
    logic          w_event;

    logic          r_moveValid;
    logic [1:0]    r_moveDir;
    logic          r_overrun;

    // Two-flop synchroniser for the asynchronous button pins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= i_btn_raw;
            r_sync2 <= r_sync1;
        end
    end

    // Per-button debounce: a bit only flips after the synced level has
    // disagreed with it for DEB_CYCLES consecutive cycles. Any agreeing
    // cycle restarts the count, so short glitches never get through.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_btnStable <= '0;
            for (int i = 0; i < 4; i++) r_debCnt[i] <= '0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (r_sync2[i] == r_btnStable[i]) begin
                    r_debCnt[i] <= '0;
                end else if (r_debCnt[i] == CW'(DEB_CYCLES - 1)) begin
                    r_btnStable[i] <= ~r_btnStable[i];
                    r_debCnt[i]    <= '0;
                end else begin
                    r_debCnt[i] <= r_debCnt[i] + CW'(1);
                end
            end
        end
    end

    // Fixed priority among held buttons: up > down > left > right.
    always_comb begin
        w_any = |r_btnStable;
        if (r_btnStable[0])      w_sel = 2'd0;
        else if (r_btnStable[1]) w_sel = 2'd1;
        else if (r_btnStable[2]) w_sel = 2'd2;
        else                     w_sel = 2'd3;
    end

    // Event FSM state register: state, repeat timer and the direction
    // currently being held.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_timer  <= '0;
            r_curDir <= 2'd0;
        end else begin
            r_state  <= w_stateNext;
            r_timer  <= w_timerNext;
            r_curDir <= w_curDirNext;
        end
    end

    // Event FSM next state. A change of selected direction always restarts
    // the long initial delay, so switching buttons feels like a fresh press.
    always_comb begin
        w_stateNext  = r_state;
        w_timerNext  = r_timer;
        w_curDirNext = r_curDir;
        if (!i_ena) begin
            w_stateNext = IDLE;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_any) begin
                        w_stateNext  = DELAY;
                        w_timerNext  = '0;
                        w_curDirNext = w_sel;
                    end
                end
                DELAY: begin
                    if (!w_any) begin
                        w_stateNext = IDLE;
                    end else if (w_sel != r_curDir) begin
                        w_timerNext  = '0;
                        w_curDirNext = w_sel;
                    end else if (r_timer == TW'(REP_DELAY - 1)) begin
                        w_stateNext = REPEAT;
                        w_timerNext = '0;
                    end else begin
                        w_timerNext = r_timer + TW'(1);
                    end
                end
                REPEAT: begin
                    if (!w_any) begin
                        w_stateNext = IDLE;
                    end else if (w_sel != r_curDir) begin
                        w_stateNext  = DELAY;
                        w_timerNext  = '0;
                        w_curDirNext = w_sel;
                    end else if (r_timer == TW'(REP_PERIOD - 1)) begin
                        w_timerNext = '0;
                    end else begin
                        w_timerNext = r_timer + TW'(1);
                    end
                end
                default: w_stateNext = IDLE;
            endcase
        end
    end

    // Event FSM output: one-cycle move event. Its direction is always the
    // current selection, since every emitting branch either keeps or adopts it.
    always_comb begin
        w_event = 1'b0;
        if (i_ena && w_any) begin
            case (r_state)
                IDLE:    w_event = 1'b1;
                DELAY:   w_event = (w_sel != r_curDir) || (r_timer == TW'(REP_DELAY - 1));
                REPEAT:  w_event = (w_sel != r_curDir) || (r_timer == TW'(REP_PERIOD - 1));
                default: w_event = 1'b0;
            endcase
        end
    end

    // One-entry output register. An event is accepted when the slot is empty
    // or being emptied this cycle; otherwise it is lost and flagged stickily.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_moveValid <= 1'b0;
            r_moveDir   <= 2'd0;
            r_overrun   <= 1'b0;
        end else if (w_event) begin
            if (!r_moveValid || move_bus.move_ready) begin
                r_moveValid <= 1'b1;
                r_moveDir   <= w_sel;
            end else begin
                r_overrun <= 1'b1;
            end
        end else if (r_moveValid && move_bus.move_ready) begin
            r_moveValid <= 1'b0;
        end
    end

    assign move_bus.move_valid = r_moveValid;
    assign move_bus.move_dir   = r_moveDir;
    assign o_btn_stable        = r_btnStable;
    assign o_overrun           = r_overrun;

endmodule

// File: tb/tb_maze_move_input.sv
// ---------------------------------------------------------------------------
// tb_maze_move_input
// Self-checking bench for maze_move_input with DEB_CYCLES=4, REP_DELAY=8,
// REP_PERIOD=4. A behavioural model tracks what the outputs must be and is
// compared every cycle; directed sequences pin the model with literal values.
// ---------------------------------------------------------------------------
module tb_maze_move_input;

    localparam int DEB = 4;
    localparam int RDL = 8;
    localparam int RPR = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ena;
    logic [3:0] btnRaw;
    logic [3:0] btnStable;
    logic       overrun;

    int checkCount = 0;
    int failCount  = 0;

    maze_move_input_if moveIf ();

    maze_move_input #(
        .DEB_CYCLES (DEB),
        .REP_DELAY  (RDL),
        .REP_PERIOD (RPR)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_ena        (ena),
        .i_btn_raw    (btnRaw),
        .move_bus     (moveIf),
        .o_btn_stable (btnStable),
        .o_overrun    (overrun)
    );

    always #5 clk = ~clk;

    // Model state: the last two raw samples, the debounced levels with their
    // run of disagreeing cycles, the held direction with its age since the
    // last emitted move, and the output slot.
    logic [3:0] mPipe [2];
    logic [3:0] mStable;
    int         mRun [4];
    int         mLastDir;
    int         mAge;
    bit         mRepeating;
    logic       mValid;
    logic [1:0] mDir;
    logic       mOverrun;

    task automatic checkOutput(input string name, input logic [3:0] actual, input logic [3:0] expected);
        checkCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic [3:0] raw, input logic en, input logic rdy);
        btnRaw            = raw;
        ena               = en;
        moveIf.move_ready = rdy;
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic countValid(input int n, output int cnt);
        cnt = 0;
        repeat (n) begin
            step(1);
            if (moveIf.move_valid === 1'b1 || btnStable !== 4'b0 && n < 0) cnt++;
        end
    endtask

    task automatic modelReset();
        mPipe[0]   = '0;
        mPipe[1]   = '0;
        mStable    = '0;
        for (int i = 0; i < 4; i++) mRun[i] = 0;
        mLastDir   = -1;
        mAge       = 0;
        mRepeating = 0;
        mValid     = 0;
        mDir       = 2'd0;
        mOverrun   = 0;
    endtask

    // One clock of model behaviour, from the inputs held across the next edge.
    task automatic modelAdvance();
        int sel;
        bit ev;
        sel = -1;
        ev  = 0;
        for (int i = 3; i >= 0; i--) if (mStable[i]) sel = i;
        if (!ena || sel < 0) begin
            mLastDir = -1;
        end else if (sel != mLastDir) begin
            ev = 1; mLastDir = sel; mAge = 0; mRepeating = 0;
        end else begin
            mAge++;
            if (!mRepeating && mAge == RDL) begin
                ev = 1; mRepeating = 1; mAge = 0;
            end else if (mRepeating && mAge == RPR) begin
                ev = 1; mAge = 0;
            end
        end
        if (ev) begin
            if (!mValid || moveIf.move_ready) begin
                mValid = 1;
                mDir   = 2'(sel);
            end else begin
                mOverrun = 1;
            end
        end else if (mValid && moveIf.move_ready) begin
            mValid = 0;
        end
        for (int i = 0; i < 4; i++) begin
            if (mPipe[1][i] != mStable[i]) begin
                mRun[i]++;
                if (mRun[i] == DEB) begin
                    mStable[i] = ~mStable[i];
                    mRun[i]    = 0;
                end
            end else begin
                mRun[i] = 0;
            end
        end
        mPipe[1] = mPipe[0];
        mPipe[0] = btnRaw;
    endtask

    // Compare process: every falling edge the DUT outputs are checked against
    // the model, then the model steps over the coming rising edge.
    initial begin
        modelReset();
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                modelReset();
                checkOutput("rst_valid", {3'b0, moveIf.move_valid}, 4'h0);
                checkOutput("rst_dir", {2'b0, moveIf.move_dir}, 4'h0);
                checkOutput("rst_stable", btnStable, 4'h0);
                checkOutput("rst_overrun", {3'b0, overrun}, 4'h0);
            end else begin
                checkOutput("valid", {3'b0, moveIf.move_valid}, {3'b0, mValid});
                if (mValid) checkOutput("dir", {2'b0, moveIf.move_dir}, {2'b0, mDir});
                checkOutput("stable", btnStable, mStable);
                checkOutput("overrun", {3'b0, overrun}, {3'b0, mOverrun});
                modelAdvance();
            end
        end
    end

    // Directed sequences followed by randomised button activity.
    initial begin
        int cnt;
        rst_n = 1'b0;
        applyStimulus(4'b1111, 1'b1, 1'b1);
        step(3);
        checkOutput("reset_valid", {3'b0, moveIf.move_valid}, 4'h0);
        checkOutput("reset_stable", btnStable, 4'h0);
        checkOutput("reset_overrun", {3'b0, overrun}, 4'h0);
        rst_n = 1'b1;
        applyStimulus(4'b0000, 1'b1, 1'b1);
        step(10);
        checkOutput("post_reset_valid", {3'b0, moveIf.move_valid}, 4'h0);
        checkOutput("post_reset_stable", btnStable, 4'h0);

        // Single left press held five cycles.
        applyStimulus(4'b0100, 1'b1, 1'b1);
        step(5);
        checkOutput("press_stable_early", btnStable, 4'h0);
        applyStimulus(4'b0000, 1'b1, 1'b1);
        step(1);
        checkOutput("press_stable_rise", btnStable, 4'b0100);
        checkOutput("press_valid_early", {3'b0, moveIf.move_valid}, 4'h0);
        step(1);
        checkOutput("press_valid", {3'b0, moveIf.move_valid}, 4'h1);
        checkOutput("press_dir", {2'b0, moveIf.move_dir}, 4'h2);
        countValid(20, cnt);
        checkOutput("press_single_pulse", 4'(cnt), 4'h0);

        // Three-cycle glitch on up.
        applyStimulus(4'b0001, 1'b1, 1'b1);
        step(3);
        applyStimulus(4'b0000, 1'b1, 1'b1);
        cnt = 0;
        repeat (15) begin
            step(1);
            if (moveIf.move_valid === 1'b1 || btnStable !== 4'b0) cnt++;
        end
        checkOutput("glitch_rejected", 4'(cnt), 4'h0);

        // Hold right: moves after 7, 15, 19, 23 cycles.
        applyStimulus(4'b1000, 1'b1, 1'b1);
        step(7);
        checkOutput("hold_first", {1'b0, moveIf.move_valid, moveIf.move_dir}, 4'b0111);
        step(4);
        checkOutput("hold_gap", {3'b0, moveIf.move_valid}, 4'h0);
        step(4);
        checkOutput("hold_rep1", {1'b0, moveIf.move_valid, moveIf.move_dir}, 4'b0111);
        step(4);
        checkOutput("hold_rep2", {1'b0, moveIf.move_valid, moveIf.move_dir}, 4'b0111);
        step(4);
        checkOutput("hold_rep3", {1'b0, moveIf.move_valid, moveIf.move_dir}, 4'b0111);
        applyStimulus(4'b0000, 1'b1, 1'b1);
        step(8);
        countValid(20, cnt);
        checkOutput("hold_release", 4'(cnt), 4'h0);

        // Back-pressure while holding up.
        applyStimulus(4'b0001, 1'b1, 1'b0);
        step(7);
        checkOutput("bp_first", {1'b0, moveIf.move_valid, moveIf.move_dir}, 4'b0100);
        checkOutput("bp_no_overrun", {3'b0, overrun}, 4'h0);
        step(10);
        checkOutput("bp_held", {1'b0, moveIf.move_valid, moveIf.move_dir}, 4'b0100);
        checkOutput("bp_overrun", {3'b0, overrun}, 4'h1);
        applyStimulus(4'b0001, 1'b1, 1'b1);
        step(1);
        checkOutput("bp_drained", {3'b0, moveIf.move_valid}, 4'h0);
        step(1);
        checkOutput("bp_next_repeat", {1'b0, moveIf.move_valid, moveIf.move_dir}, 4'b0100);
        applyStimulus(4'b0000, 1'b1, 1'b1);
        step(20);

        // Priority: down+left, then release down, then drop enable.
        applyStimulus(4'b0110, 1'b1, 1'b1);
        step(7);
        checkOutput("prio_down", {1'b0, moveIf.move_valid, moveIf.move_dir}, 4'b0101);
        applyStimulus(4'b0100, 1'b1, 1'b1);
        step(6);
        checkOutput("prio_quiet", {3'b0, moveIf.move_valid}, 4'h0);
        step(1);
        checkOutput("prio_left", {1'b0, moveIf.move_valid, moveIf.move_dir}, 4'b0110);
        applyStimulus(4'b0100, 1'b0, 1'b1);
        step(1);
        countValid(30, cnt);
        checkOutput("ena_low_no_moves", 4'(cnt), 4'h0);
        applyStimulus(4'b0100, 1'b1, 1'b1);
        step(1);
        checkOutput("ena_back_move", {1'b0, moveIf.move_valid, moveIf.move_dir}, 4'b0110);
        step(2);

        // Randomised activity checked only by the model.
        for (int seg = 0; seg < 80; seg++) begin
            int kind;
            int len;
            logic [3:0] pat;
            kind = $urandom_range(0, 9);
            len  = $urandom_range(1, 40);
            if (kind < 5)      pat = 4'(4'b0001 << $urandom_range(0, 3));
            else if (kind < 7) pat = 4'b0000;
            else               pat = 4'($urandom_range(0, 15));
            for (int c = 0; c < len; c++) begin
                applyStimulus(pat, ($urandom_range(0, 40) != 0), ($urandom_range(0, 3) != 0));
                step(1);
            end
        end

        // Asynchronous reset in the middle of a held press.
        applyStimulus(4'b0001, 1'b1, 1'b0);
        step(25);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("async_valid", {3'b0, moveIf.move_valid}, 4'h0);
        checkOutput("async_dir", {2'b0, moveIf.move_dir}, 4'h0);
        checkOutput("async_stable", btnStable, 4'h0);
        checkOutput("async_overrun", {3'b0, overrun}, 4'h0);
        step(3);
        rst_n = 1'b1;
        applyStimulus(4'b0000, 1'b1, 1'b1);
        step(10);
        checkOutput("final_valid", {3'b0, moveIf.move_valid}, 4'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
        $finish;
    end

endmodule

// File: doc/maze_move_input.md
Name: maze_move_input

Overview:
- Input-conditioning stage directly upstream of the maze game core, inside the chip top.
- Takes four raw direction buttons from the dedicated input pins, then synchronises and debounces them.
- Converts the debounced button levels into single move commands, with hold-to-repeat.
- Delivers each move to the maze core over a valid/ready handshake, through a one-entry output register.

Parameters:
DEB_CYCLES, 16, consecutive cycles a synced input must differ from its stable level before the stable level flips (>=1)
REP_DELAY, 64, cycles after an initial move before the first auto-repeat (>=1)
REP_PERIOD, 16, cycles between auto-repeats once repeating (>=1)

Ports:
clk  input  1  system clock; all state on rising edge
rst_n  input  1  asynchronous, active-low reset
ena  input  1  design enable; when low, no new moves are generated
btn_raw  input  4  raw, unsynchronised buttons: [0]=up, [1]=down, [2]=left, [3]=right; active high
move_ready  input  1  maze core accepts the presented move this cycle
move_valid  output  1  a move is presented
move_dir  output  2  00=up, 01=down, 10=left, 11=right; meaningful only while move_valid=1
btn_stable  output  4  debounced button levels
overrun  output  1  sticky flag: a move was dropped because the output register was occupied

Behaviour:
- Reset: asserting rst_n low immediately clears all state, including in the middle of an operation.
  - Cleared state: synchronisers, debounce counters, btn_stable, FSM (returns to IDLE), timers, move_valid, move_dir, overrun.
  - After release, operation restarts from IDLE with btn_stable=0.
- Synchroniser: two flops per bit.
- Debounce, per bit, counter width $clog2(DEB_CYCLES+1):
  - synced==stable: counter clears to 0.
  - synced!=stable: counter increments.
  - When the counter reaches DEB_CYCLES, the stable bit flips on that same edge and the counter clears.
  - Glitches shorter than DEB_CYCLES cycles never reach btn_stable.
  - Raw-to-stable latency is DEB_CYCLES+2 cycles.
- Direction select: sel = lowest-index set bit of btn_stable (up > down > left > right); any = |btn_stable.
- Event FSM (IDLE, DELAY, REPEAT), timer width sized for max(REP_DELAY, REP_PERIOD):
  - IDLE: if any and ena, emit event(sel), latch cur_dir=sel, timer=0, go to DELAY.
  - DELAY:
    - !any: go to IDLE, no event.
    - sel!=cur_dir: emit event(sel), cur_dir=sel, timer=0, stay in DELAY.
    - timer==REP_DELAY-1: emit event(cur_dir), timer=0, go to REPEAT.
    - otherwise: timer++.
  - REPEAT:
    - !any: go to IDLE.
    - sel!=cur_dir: emit event, timer=0, go to DELAY.
    - timer==REP_PERIOD-1: emit event, timer=0.
    - otherwise: timer++.
  - ena=0: the FSM is forced to IDLE and no event is emitted. The output register keeps any pending move.
- Output register (one entry):
  - An event in a cycle where move_valid=0, or move_valid=1 with move_ready=1, loads the register. Next cycle: move_valid=1, move_dir=event dir.
  - An event in a cycle where move_valid=1 and move_ready=0 is dropped, and overrun is set to 1. overrun stays 1 until reset.
  - move_valid=1 with move_ready=1 and no event: move_valid drops to 0 next cycle.
  - While move_valid=1 and move_ready=0, move_dir is held constant.
- Latency: move_valid rises 1 cycle after btn_stable rises, i.e. DEB_CYCLES+3 cycles after btn_raw rises.
- Simultaneous buttons: priority picks sel.
  - Releasing the higher-priority button while the lower one is still held counts as a direction change, so it emits immediately.
- Releasing all buttons never emits a move.

Test Plan (DEB_CYCLES=4, REP_DELAY=8, REP_PERIOD=4, move_ready=1 unless stated):
1. Reset: hold rst_n=0 with btn_raw=4'b1111 -> all outputs 0. Release reset, keep btn_raw=0 -> outputs stay 0.
2. Single press: btn_raw[2]=1 at cycle t, held for 5 cycles, then released -> btn_stable[2] rises at t+6; exactly one pulse of move_valid=1 with move_dir=10 at t+7.
3. Glitch rejection: btn_raw[0] high for 3 cycles -> btn_stable and move_valid stay 0.
4. Hold-repeat: hold right (btn_raw[3]) -> moves with move_dir=11 at t+7, t+15, t+19, t+23 …. Release -> no further moves after the debounce latency.
5. Back-pressure: move_ready=0 while holding up past the first repeat -> move_valid=1, move_dir=00 held, overrun=1. Raise move_ready -> one handshake, then move_valid=0 until the next repeat.
6. Priority and ena: hold down+left -> dir 01. Release down -> immediate move with dir 10. Drop ena while still holding left -> no further moves. Assert rst_n=0 mid-hold -> outputs clear asynchronously.
